// File: rtl/result_pkg.sv
// rtl/result_pkg.sv - shared types and constants for the result merger
package result_pkg;

  // Default rule-id width, matching the solver output
  localparam int RULE_ID_W = 14;

  // Buffered result width: match bit plus rule id
  localparam int RES_W = RULE_ID_W + 1;

  // Buffered result entry, match bit in the MSB
  typedef struct packed {
    logic                 matched;
    logic [RULE_ID_W-1:0] rule_id;
  } entry_t;

  // Source lane encoding on out_lane
  localparam logic LANE1 = 1'b0;
  localparam logic LANE2 = 1'b1;

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - synchronous per-lane result FIFO, push and pop legal together when full
module result_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot on the same edge, so a full FIFO can still accept a push
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy tracking; depth is a power of two so pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/result_merger.sv
// rtl/result_merger.sv - buffers two solver lanes and round-robin merges them into one result stream
module result_merger
  import result_pkg::*;
#(
  parameter int RULE_ID    = 14,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 32
) (
  input  logic               clk,
  input  logic               RST,
  input  logic [RULE_ID-1:0] rule_id1,
  input  logic               is_matched1,
  input  logic               data_valid_in1,
  input  logic [RULE_ID-1:0] rule_id2,
  input  logic               is_matched2,
  input  logic               data_valid_in2,
  output logic [RULE_ID-1:0] out_rule_id,
  output logic               out_matched,
  output logic               out_lane,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               overflow1,
  output logic               overflow2,
  input  logic               clr_stats,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [CNT_W-1:0]   miss_cnt
);

  localparam int W = RULE_ID + 1;

  logic [W-1:0] head1;
  logic [W-1:0] head2;
  logic         full1;
  logic         full2;
  logic         empty1;
  logic         empty2;
  logic         pop1;
  logic         pop2;
  logic         load;
  logic         handshake;
  logic         drop1;
  logic         drop2;
  logic         rr_ptr;

  // Output register may take a new result when empty or being consumed this edge
  assign load      = !out_valid || out_ready;
  assign handshake = out_valid && out_ready;

  // Arbitration on registered FIFO state only; round-robin breaks ties
  assign pop1 = load && !empty1 && (empty2 || rr_ptr == LANE1);
  assign pop2 = load && !empty2 && (empty1 || rr_ptr == LANE2);

  // Solver lanes cannot be stalled: a write into a full FIFO with no pop is lost
  assign drop1 = data_valid_in1 && full1 && !pop1;
  assign drop2 = data_valid_in2 && full2 && !pop2;

  result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (W)
  ) u_fifo1 (
    .clk       (clk),
    .rst       (RST),
    .push      (data_valid_in1),
    .push_data ({is_matched1, rule_id1}),
    .pop       (pop1),
    .pop_data  (head1),
    .full      (full1),
    .empty     (empty1)
  );

  result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (W)
  ) u_fifo2 (
    .clk       (clk),
    .rst       (RST),
    .push      (data_valid_in2),
    .push_data ({is_matched2, rule_id2}),
    .pop       (pop2),
    .pop_data  (head2),
    .full      (full2),
    .empty     (empty2)
  );

  // Output register and round-robin pointer; pointer advances only on a contended pop
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      out_rule_id <= '0;
      out_matched <= 1'b0;
      out_lane    <= LANE1;
      out_valid   <= 1'b0;
      rr_ptr      <= LANE1;
    end else if (load) begin
      if (pop1) begin
        {out_matched, out_rule_id} <= head1;
        out_lane                   <= LANE1;
        out_valid                  <= 1'b1;
        if (!empty2) rr_ptr <= LANE2;
      end else if (pop2) begin
        {out_matched, out_rule_id} <= head2;
        out_lane                   <= LANE2;
        out_valid                  <= 1'b1;
        if (!empty1) rr_ptr <= LANE1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // Delivered hit/miss counters, saturating; clear beats a same-edge increment
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (clr_stats) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (handshake) begin
      if (out_matched) begin
        if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
      end else begin
        if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
      end
    end
  end

  // Sticky drop flags; a new drop beats a same-edge clear
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      overflow1 <= 1'b0;
      overflow2 <= 1'b0;
    end else begin
      if (drop1)          overflow1 <= 1'b1;
      else if (clr_stats) overflow1 <= 1'b0;
      if (drop2)          overflow2 <= 1'b1;
      else if (clr_stats) overflow2 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_result_merger.sv
// tb/tb_result_merger.sv - scoreboard bench for result_merger
module tb_result_merger;

  localparam int RULE_ID = 14;
  localparam int DEPTH   = 8;
  localparam int CNT_W   = 32;

  logic               clk = 1'b0;
  logic               RST = 1'b1;
  logic [RULE_ID-1:0] rule_id1 = '0;
  logic               is_matched1 = 1'b0;
  logic               data_valid_in1 = 1'b0;
  logic [RULE_ID-1:0] rule_id2 = '0;
  logic               is_matched2 = 1'b0;
  logic               data_valid_in2 = 1'b0;
  logic [RULE_ID-1:0] out_rule_id;
  logic               out_matched;
  logic               out_lane;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic               overflow1;
  logic               overflow2;
  logic               clr_stats = 1'b0;
  logic [CNT_W-1:0]   hit_cnt;
  logic [CNT_W-1:0]   miss_cnt;

  result_merger #(
    .RULE_ID    (RULE_ID),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk            (clk),
    .RST            (RST),
    .rule_id1       (rule_id1),
    .is_matched1    (is_matched1),
    .data_valid_in1 (data_valid_in1),
    .rule_id2       (rule_id2),
    .is_matched2    (is_matched2),
    .data_valid_in2 (data_valid_in2),
    .out_rule_id    (out_rule_id),
    .out_matched    (out_matched),
    .out_lane       (out_lane),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .overflow1      (overflow1),
    .overflow2      (overflow2),
    .clr_stats      (clr_stats),
    .hit_cnt        (hit_cnt),
    .miss_cnt       (miss_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected per-lane results {matched, rule_id} and observed delivery order {lane, matched, rule_id}
  logic [RULE_ID:0]   exp_q1[$];
  logic [RULE_ID:0]   exp_q2[$];
  logic [RULE_ID+1:0] order_q[$];
  int                 n_deliv = 0;
  logic               stall_prev = 1'b0;
  logic [RULE_ID+1:0] prev_word = '0;

  // Monitor between edges: score handshakes and check stability while stalled
  always @(negedge clk) begin
    if (RST) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 64'(out_valid), 64'(1));
        chk("stall_hold", 64'({out_lane, out_matched, out_rule_id}), 64'(prev_word));
      end
      if (out_valid && out_ready) begin
        if (out_lane == 1'b0) begin
          chk("lane1_expected", 64'(exp_q1.size() > 0), 64'(1));
          if (exp_q1.size() > 0) chk("lane1_data", 64'({out_matched, out_rule_id}), 64'(exp_q1.pop_front()));
        end else begin
          chk("lane2_expected", 64'(exp_q2.size() > 0), 64'(1));
          if (exp_q2.size() > 0) chk("lane2_data", 64'({out_matched, out_rule_id}), 64'(exp_q2.pop_front()));
        end
        n_deliv++;
        order_q.push_back({out_lane, out_matched, out_rule_id});
      end
      stall_prev = out_valid && !out_ready;
      prev_word  = {out_lane, out_matched, out_rule_id};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic [RULE_ID-1:0] id, input logic m, input bit expect_it);
    rule_id1 = id; is_matched1 = m; data_valid_in1 = 1'b1;
    if (expect_it) exp_q1.push_back({m, id});
  endtask

  task automatic drive2(input logic [RULE_ID-1:0] id, input logic m, input bit expect_it);
    rule_id2 = id; is_matched2 = m; data_valid_in2 = 1'b1;
    if (expect_it) exp_q2.push_back({m, id});
  endtask

  task automatic idle_inputs();
    data_valid_in1 = 1'b0;
    data_valid_in2 = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles, input bit toggle);
    for (int c = 0; c < max_cycles; c++) begin
      if (exp_q1.size() == 0 && exp_q2.size() == 0 && !out_valid) break;
      if (toggle) out_ready = ~out_ready;
      tick();
    end
    chk("drain_left", 64'(exp_q1.size() + exp_q2.size()), 64'(0));
    chk("drain_valid", 64'(out_valid), 64'(0));
  endtask

  int snap;
  logic [RULE_ID-1:0] exp_order [8];

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    // Reset state
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_id", 64'(out_rule_id), 64'(0));
    chk("rst_hit", 64'(hit_cnt), 64'(0));
    chk("rst_miss", 64'(miss_cnt), 64'(0));
    chk("rst_ovf", 64'({overflow1, overflow2}), 64'(0));
    RST = 1'b0;
    tick();

    // 1: single lane-1 match, one-cycle latency
    out_ready = 1'b1;
    drive1(14'h0123, 1'b1, 1'b1);
    tick();
    idle_inputs();
    chk("t1_not_yet", 64'(out_valid), 64'(0));
    tick();
    chk("t1_valid", 64'(out_valid), 64'(1));
    chk("t1_id", 64'(out_rule_id), 64'(14'h0123));
    chk("t1_lane", 64'(out_lane), 64'(0));
    tick();
    chk("t1_hit", 64'(hit_cnt), 64'(1));
    chk("t1_idle", 64'(out_valid), 64'(0));

    // 2: both lanes, alternating order
    order_q.delete();
    for (int i = 1; i <= 4; i++) begin
      drive1(14'(i), 1'(i % 2), 1'b1);
      drive2(14'(10 + i), 1'((i + 1) % 2), 1'b1);
      tick();
    end
    idle_inputs();
    wait_drain(40, 1'b0);
    exp_order = '{14'd1, 14'd11, 14'd2, 14'd12, 14'd3, 14'd13, 14'd4, 14'd14};
    chk("t2_count", 64'(order_q.size()), 64'(8));
    for (int k = 0; k < 8; k++)
      if (k < order_q.size()) chk("t2_order", 64'(order_q[k][RULE_ID-1:0]), 64'(exp_order[k]));

    // 3: lane-2 overflow while stalled (one result parks in the output register)
    pulse_clr();
    out_ready = 1'b0;
    snap = n_deliv;
    for (int i = 0; i < 10; i++) begin
      drive2(14'h100 + 14'(i), 1'b1, i < 9);
      tick();
      if (i == 8) chk("t3_no_ovf_yet", 64'(overflow2), 64'(0));
      if (i == 9) begin
        chk("t3_ovf2", 64'(overflow2), 64'(1));
        chk("t3_ovf1", 64'(overflow1), 64'(0));
      end
    end
    idle_inputs();
    out_ready = 1'b1;
    wait_drain(40, 1'b0);
    chk("t3_delivered", 64'(n_deliv - snap), 64'(9));
    chk("t3_ovf_sticky", 64'(overflow2), 64'(1));

    // 4: lane-1 misses with toggling ready
    pulse_clr();
    chk("t4_ovf_cleared", 64'(overflow2), 64'(0));
    snap = n_deliv;
    for (int k = 0; k < 16; k++) begin
      out_ready = (k % 2 == 0);
      if (k % 2 == 0) drive1(14'h200 + 14'(k), 1'b0, 1'b1);
      tick();
      idle_inputs();
    end
    wait_drain(60, 1'b1);
    out_ready = 1'b1;
    chk("t4_miss_vs_deliv", 64'(miss_cnt), 64'(n_deliv - snap));
    chk("t4_miss", 64'(miss_cnt), 64'(8));
    chk("t4_ovf1", 64'(overflow1), 64'(0));

    // 5: full FIFO with pop and push on one edge, clear during handshake
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive1(14'h300 + 14'(i), 1'b1, 1'b1);
      tick();
    end
    chk("t5_full_no_ovf", 64'(overflow1), 64'(0));
    out_ready = 1'b1;
    clr_stats = 1'b1;
    drive1(14'h309, 1'b1, 1'b1);
    tick();
    idle_inputs();
    clr_stats = 1'b0;
    out_ready = 1'b0;
    chk("t5_clr_hit", 64'(hit_cnt), 64'(0));
    chk("t5_clr_miss", 64'(miss_cnt), 64'(0));
    chk("t5_ovf1", 64'(overflow1), 64'(0));
    snap = n_deliv;
    out_ready = 1'b1;
    wait_drain(40, 1'b0);
    chk("t5_hits", 64'(hit_cnt), 64'(9));
    chk("t5_hit_vs_deliv", 64'(hit_cnt), 64'(n_deliv - snap));

    // 6: asynchronous reset with buffered data, then fresh traffic
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive1(14'h3A0 + 14'(i), 1'b0, 1'b0);
      drive2(14'h3B0 + 14'(i), 1'b1, 1'b0);
      tick();
    end
    idle_inputs();
    chk("t6_pre_valid", 64'(out_valid), 64'(1));
    #2;
    RST = 1'b1;
    #1;
    chk("t6_rst_outs", 64'({out_valid, out_lane, out_matched, out_rule_id}), 64'(0));
    chk("t6_rst_cnt", 64'(hit_cnt | miss_cnt), 64'(0));
    tick();
    tick();
    RST = 1'b0;
    out_ready = 1'b1;
    order_q.delete();
    drive1(14'h3AA, 1'b0, 1'b1);
    drive2(14'h3BB, 1'b1, 1'b1);
    tick();
    idle_inputs();
    wait_drain(40, 1'b0);
    chk("t6_count", 64'(order_q.size()), 64'(2));
    if (order_q.size() == 2) begin
      chk("t6_first", 64'(order_q[0]), 64'({1'b0, 1'b0, 14'h3AA}));
      chk("t6_second", 64'(order_q[1]), 64'({1'b1, 1'b1, 14'h3BB}));
    end
    chk("t6_hit", 64'(hit_cnt), 64'(1));
    chk("t6_miss", 64'(miss_cnt), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
